// File: rtl/stopwatch_ctrl.sv
// Millisecond stopwatch controller: button conditioning, IDLE/RUN/PAUSE/HALT sequencing, 4-digit BCD count.
// Define STOPWATCH_WRAP_EN to wrap 9.999 -> 0.000 in RUN instead of halting.
module stopwatch_ctrl #(
    parameter int unsigned CLKS_PER_TICK   = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_TICKS     = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] bcd,
    output logic        en_dec_pt,
    output logic        running
);

    localparam int unsigned PW = (CLKS_PER_TICK > 1)   ? $clog2(CLKS_PER_TICK)   : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1)     ? $clog2(BLINK_TICKS)     : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_HALT
    } state_t;

    // Button conditioning; index 0 is start_stop, index 1 is clear.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_prev_q;
    logic [1:0]    press_q;
    logic [DW-1:0] dbc_q [2];

    assign btn_raw = {btn_clear, btn_start_stop};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    dbc_q[i] <= '0;
                    db_q[i]  <= sync2_q[i];
                end else begin
                    dbc_q[i] <= dbc_q[i] + 1'b1;
                end
            end
        end
    end

    logic ss_press;
    logic clr_press;

    assign ss_press  = press_q[0];
    assign clr_press = press_q[1];

    state_t        state_q;
    logic [15:0]   bcd_q;
    logic          en_q;
    logic          run_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] blink_q;

    logic          tick;
    logic          at_max;
    logic          halt_now;
    logic          carry;
    logic [15:0]   bcd_inc;

    // Prescaler sits at 0 in IDLE so the first increment after a start is a full tick away.
    assign tick   = (state_q != S_IDLE) && (presc_q == PW'(CLKS_PER_TICK - 1));
    assign at_max = (bcd_q == 16'h9999);

`ifdef STOPWATCH_WRAP_EN
    assign halt_now = 1'b0;
`else
    assign halt_now = tick && at_max;
`endif

    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_press) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            en_q    <= 1'b1;
            run_q   <= 1'b0;
            presc_q <= '0;
            blink_q <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (ss_press) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A tick landing with a press still counts; reaching the halt wins over pausing.
                    if (tick && !halt_now) begin
                        bcd_q <= bcd_inc;
                    end
                    if (halt_now) begin
                        state_q <= S_HALT;
                        run_q   <= 1'b0;
                    end else if (ss_press) begin
                        state_q <= S_PAUSE;
                        run_q   <= 1'b0;
                        blink_q <= '0;
                    end
                end
                S_PAUSE: begin
                    if (ss_press) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                        en_q    <= 1'b1;
                    end else if (tick) begin
                        if (blink_q == BW'(BLINK_TICKS - 1)) begin
                            blink_q <= '0;
                            en_q    <= ~en_q;
                        end else begin
                            blink_q <= blink_q + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd       = bcd_q;
    assign en_dec_pt = en_q;
    assign running   = run_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (CLKS_PER_TICK=4, DEBOUNCE_CYCLES=3, BLINK_TICKS=2).
// Honors STOPWATCH_WRAP_EN the same way the design does.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_start_stop;
    logic        btn_clear;
    logic [15:0] bcd;
    logic        en_dec_pt;
    logic        running;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .CLKS_PER_TICK  (4),
        .DEBOUNCE_CYCLES(3),
        .BLINK_TICKS    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .bcd           (bcd),
        .en_dec_pt     (en_dec_pt),
        .running       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raw press held 4 cycles; the resulting state change lands on edge k+7,
    // and the task returns 1 ns after that edge.
    task automatic press(input logic ss, input logic clr);
        btn_start_stop = ss;
        btn_clear      = clr;
        step(4);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        step(3);
    endtask

    initial begin
        rst            = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        step(3);
        chk("reset_bcd", bcd, 16'h0000);
        chk("reset_dp", {15'd0, en_dec_pt}, 16'd1);
        chk("reset_run", {15'd0, running}, 16'd0);
        rst = 1'b0;
        step(2);

        // Start and decade carries; increments land every 4 edges after the start edge.
        press(1'b1, 1'b0);
        chk("start_run", {15'd0, running}, 16'd1);
        chk("start_bcd", bcd, 16'h0000);
        step(36);
        chk("cnt_0009", bcd, 16'h0009);
        step(4);
        chk("cnt_0010", bcd, 16'h0010);
        chk("cnt_run", {15'd0, running}, 16'd1);
        step(356);
        chk("cnt_0099", bcd, 16'h0099);
        step(4);
        chk("cnt_0100", bcd, 16'h0100);
        step(3596);
        chk("cnt_0999", bcd, 16'h0999);
        step(4);
        chk("cnt_1000", bcd, 16'h1000);

        // Clear from RUN.
        step(1);
        press(1'b0, 1'b1);
        chk("clr_bcd", bcd, 16'h0000);
        chk("clr_run", {15'd0, running}, 16'd0);
        chk("clr_dp", {15'd0, en_dec_pt}, 16'd1);
        step(5);

        // Pause at 0.005: pause edge P = start+22, PAUSE ticks at P+2+4m, blink toggles at P+6+8j.
        press(1'b1, 1'b0);
        step(15);
        press(1'b1, 1'b0);
        chk("pause_bcd", bcd, 16'h0005);
        chk("pause_run", {15'd0, running}, 16'd0);
        chk("pause_dp0", {15'd0, en_dec_pt}, 16'd1);
        step(5);
        chk("pause_dp5", {15'd0, en_dec_pt}, 16'd1);
        step(1);
        chk("pause_dp6", {15'd0, en_dec_pt}, 16'd0);
        step(7);
        chk("pause_dp13", {15'd0, en_dec_pt}, 16'd0);
        step(1);
        chk("pause_dp14", {15'd0, en_dec_pt}, 16'd1);
        step(82);
        chk("pause_dp96", {15'd0, en_dec_pt}, 16'd1);
        chk("pause_bcd96", bcd, 16'h0005);
        // Resume at P+103 while the point is dark; next increment comes from the held phase.
        press(1'b1, 1'b0);
        chk("resume_run", {15'd0, running}, 16'd1);
        chk("resume_dp", {15'd0, en_dec_pt}, 16'd1);
        chk("resume_bcd", bcd, 16'h0005);
        step(2);
        chk("resume_hold", bcd, 16'h0005);
        step(1);
        chk("resume_inc", bcd, 16'h0006);

        // Clear and start_stop together in RUN.
        press(1'b1, 1'b1);
        chk("both_run", {15'd0, running}, 16'd0);
        chk("both_bcd", bcd, 16'h0000);
        chk("both_dp", {15'd0, en_dec_pt}, 16'd1);
        step(20);
        chk("both_idle_run", {15'd0, running}, 16'd0);
        chk("both_idle_bcd", bcd, 16'h0000);

        // Two-cycle glitch.
        btn_start_stop = 1'b1;
        step(2);
        btn_start_stop = 1'b0;
        step(12);
        chk("glitch_run", {15'd0, running}, 16'd0);
        chk("glitch_bcd", bcd, 16'h0000);

        // Held 50 cycles: one transition at k+7, 13 ticks by k+60.
        btn_start_stop = 1'b1;
        step(50);
        btn_start_stop = 1'b0;
        step(10);
        chk("hold_run", {15'd0, running}, 16'd1);
        chk("hold_bcd", bcd, 16'h0013);

        // Reset mid-run with both buttons active.
        rst            = 1'b1;
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
        step(1);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_dp", {15'd0, en_dec_pt}, 16'd1);
        chk("rst_run", {15'd0, running}, 16'd0);
        rst            = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        step(10);
        chk("post_rst_run", {15'd0, running}, 16'd0);

        // Run to the top of the range.
        press(1'b1, 1'b0);
        step(39996);
        chk("top_9999", bcd, 16'h9999);
        chk("top_run", {15'd0, running}, 16'd1);
        step(4);
`ifdef STOPWATCH_WRAP_EN
        chk("wrap_bcd", bcd, 16'h0000);
        chk("wrap_run", {15'd0, running}, 16'd1);
        step(4);
        chk("wrap_next", bcd, 16'h0001);
`else
        chk("halt_bcd", bcd, 16'h9999);
        chk("halt_run", {15'd0, running}, 16'd0);
        chk("halt_dp", {15'd0, en_dec_pt}, 16'd1);
        press(1'b1, 1'b0);
        chk("halt_ign_run", {15'd0, running}, 16'd0);
        chk("halt_ign_bcd", bcd, 16'h9999);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Millisecond stopwatch controller that feeds the four-digit seven-segment display driver. It conditions two push-buttons, sequences IDLE/RUN/PAUSE/HALT, and produces the packed 4-digit BCD value plus the decimal-point enable. The display stage consumes `bcd` and `en_dec_pt` directly, rendering `bcd[15:12]` as seconds and the lower three digits as milliseconds (X.XXX s).

## Interface
- `CLKS_PER_TICK`, 100000: clk cycles per 1 ms tick (100 MHz clk).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles required before a button's debounced level changes.
- `BLINK_TICKS`, 250: ticks between `en_dec_pt` toggles while paused.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start_stop`  in  1  raw, asynchronous start/stop button, active-high.
- `btn_clear`  in  1  raw, asynchronous clear button, active-high.
- `bcd`  out  16  packed digits `{s, ms100, ms10, ms1}`, 4 bits each, each 0–9.
- `en_dec_pt`  out  1  decimal-point enable for the display's digit 3.
- `running`  out  1  high in RUN.

## Operation
- Input path per button: 2-FF synchronizer -> debouncer (counter restarts whenever the synchronized level differs from the debounced level; debounced level updates when the counter reaches `DEBOUNCE_CYCLES`) -> rising-edge detector yielding a one-cycle press pulse.
- Prescaler: free-running counter 0..`CLKS_PER_TICK`-1. Emits a one-cycle `tick` when it wraps. Cleared by `rst` and by a clear press.
- BCD counter: 4 cascaded decade digits. On `tick` in RUN it adds 1 ms. Each digit goes 9->0 with a carry into the next digit.
- States:
  - IDLE: count 0.000. A start_stop press goes to RUN.
  - RUN: count advances on each tick. A start_stop press goes to PAUSE. Reaching 9.999 is handled per Configuration.
  - PAUSE: count frozen. A start_stop press goes to RUN; the count resumes from its held value.
  - HALT: count frozen at 9.999. A start_stop press is ignored.
- A clear press in any state zeroes the count and the prescaler and goes to IDLE.
- A clear press takes priority over a start_stop press in the same cycle.
- `en_dec_pt`:
  - 1 in IDLE, RUN and HALT.
  - In PAUSE it toggles every `BLINK_TICKS` ticks, using a blink tick counter that is cleared on entry to PAUSE.
  - It is forced to 1 on exit from PAUSE.
- `running` = (state == RUN).

## Timing
- Reset values: `bcd`=16'h0000, `en_dec_pt`=1, `running`=0, state IDLE, prescaler 0, debounced levels 0, blink counter 0.
- Debounce latency: a raw press held steady is registered as a press pulse `DEBOUNCE_CYCLES`+3 cycles after the raw edge (2 synchronizer stages + counter + edge register).
- A state change happens on the clk edge following the press pulse. `bcd`, `en_dec_pt` and `running` are registered outputs that change on that same edge.
- First count increment after a start from IDLE: `CLKS_PER_TICK` cycles after the press pulse.
- PAUSE preserves the prescaler phase, so the resume-to-next-increment time is the remainder of the interrupted tick.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.
- Holding a button produces exactly one pulse; release produces none.
- `rst` asserted mid-count returns all outputs to their reset values on the next edge, regardless of button activity.

## Configuration
- `STOPWATCH_WRAP_EN` defined: in RUN, the tick at 9.999 wraps the count to 0.000 and the block stays in RUN. HALT is unreachable.
- `STOPWATCH_WRAP_EN` undefined: in RUN, the tick at 9.999 is absorbed. The count holds 9.999 and the state goes to HALT, which `running` reports as 0.

## Test plan
Bench parameters: `CLKS_PER_TICK`=4, `DEBOUNCE_CYCLES`=3, `BLINK_TICKS`=2.
- After `rst`, press start_stop and run 40 cycles -> `bcd` = 16'h0010, `running`=1.
- Count through 0.009 -> 0.010 and 0.099 -> 0.100 -> correct decade carries on a single tick each. Count at 0.999 -> `bcd` = 16'h1000 on the next tick.
- Press start_stop in RUN at 0.005 and wait 100 cycles -> `bcd` stays 16'h0005 and `en_dec_pt` toggles every 8 cycles. Press again -> counting resumes and `en_dec_pt`=1.
- Run to 9.999 -> without the macro, `bcd` holds 16'h9999 and `running`=0, and further start_stop presses are ignored. With the macro, the count becomes 16'h0000 with `running`=1.
- Press clear and start_stop in the same cycle while in RUN -> state IDLE and `bcd`=16'h0000.
- Raw pulse 2 cycles wide -> no state change. Hold 50 cycles -> exactly one transition. Assert `rst` mid-run -> all reset values on the next edge.
